// File: rtl/rv32i_pkg.sv
// RV32I encoding constants shared by the decode stage: opcodes, funct3/funct7 values,
// op-flag bit positions and the class-enable record.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_000 = 3'b000;
    localparam logic [2:0] F3_001 = 3'b001;
    localparam logic [2:0] F3_010 = 3'b010;
    localparam logic [2:0] F3_011 = 3'b011;
    localparam logic [2:0] F3_100 = 3'b100;
    localparam logic [2:0] F3_101 = 3'b101;
    localparam logic [2:0] F3_110 = 3'b110;
    localparam logic [2:0] F3_111 = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Op-flag bit positions; each class occupies a contiguous range.
    localparam int OP_LUI    = 0;
    localparam int OP_AUIPC  = 1;
    localparam int OP_JAL    = 2;
    localparam int OP_JALR   = 3;
    localparam int OP_BEQ    = 4;
    localparam int OP_BNE    = 5;
    localparam int OP_BLT    = 6;
    localparam int OP_BGE    = 7;
    localparam int OP_BLTU   = 8;
    localparam int OP_BGEU   = 9;
    localparam int OP_LB     = 10;
    localparam int OP_LH     = 11;
    localparam int OP_LW     = 12;
    localparam int OP_LBU    = 13;
    localparam int OP_LHU    = 14;
    localparam int OP_SB     = 15;
    localparam int OP_SH     = 16;
    localparam int OP_SW     = 17;
    localparam int OP_ADDI   = 18;
    localparam int OP_SLTI   = 19;
    localparam int OP_SLTIU  = 20;
    localparam int OP_XORI   = 21;
    localparam int OP_ORI    = 22;
    localparam int OP_ANDI   = 23;
    localparam int OP_SLLI   = 24;
    localparam int OP_SRLI   = 25;
    localparam int OP_SRAI   = 26;
    localparam int OP_ADD    = 27;
    localparam int OP_SUB    = 28;
    localparam int OP_SLL    = 29;
    localparam int OP_SLT    = 30;
    localparam int OP_SLTU   = 31;
    localparam int OP_XOR    = 32;
    localparam int OP_SRL    = 33;
    localparam int OP_SRA    = 34;
    localparam int OP_OR     = 35;
    localparam int OP_AND    = 36;
    localparam int OP_FENCE  = 37;
    localparam int OP_FENCEI = 38;
    localparam int OP_ECALL  = 39;
    localparam int OP_EBREAK = 40;
    localparam int OP_CSRRW  = 41;
    localparam int OP_CSRRS  = 42;
    localparam int OP_CSRRC  = 43;
    localparam int OP_CSRRWI = 44;
    localparam int OP_CSRRSI = 45;
    localparam int OP_CSRRCI = 46;
    localparam int NUM_OPS   = 47;

    localparam int NUM_CLS = 7;

    typedef struct packed {
        logic store;
        logic load;
        logic branch;
        logic jump;
        logic reg_op;
        logic imm;
        logic upper;
    } dec_cls_t;

endpackage

// File: rtl/dec_swc_comb.sv
// Pure combinational RV32I decode: instruction word to one-hot op flags, class enables,
// register indices and raw (unextended) immediates.
module dec_swc_comb
    import rv32i_pkg::*;
(
    input  logic [31:0]        inst,
    output logic [NUM_OPS-1:0] ops,
    output logic [NUM_CLS-1:0] cls,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic [11:0]        imm_i,
    output logic [11:0]        imm_s,
    output logic [12:0]        imm_b,
    output logic [20:0]        imm_j,
    output logic [19:0]        imm_u
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    dec_cls_t   cls_s;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    assign rs2   = inst[24:20];
    assign rs1   = inst[19:15];
    assign rd    = inst[11:7];
    assign imm_i = inst[31:20];
    assign imm_s = {inst[31:25], inst[11:7]};
    assign imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u = inst[31:12];

    // The full 7-bit opcode compare also enforces inst[1:0] == 2'b11.
    always_comb begin
        ops = '0;
        case (opc)
            OPC_LUI:   ops[OP_LUI]   = 1'b1;
            OPC_AUIPC: ops[OP_AUIPC] = 1'b1;
            OPC_JAL:   ops[OP_JAL]   = 1'b1;
            OPC_JALR:  ops[OP_JALR]  = (f3 == F3_000);
            OPC_BRANCH: begin
                case (f3)
                    F3_000:  ops[OP_BEQ]  = 1'b1;
                    F3_001:  ops[OP_BNE]  = 1'b1;
                    F3_100:  ops[OP_BLT]  = 1'b1;
                    F3_101:  ops[OP_BGE]  = 1'b1;
                    F3_110:  ops[OP_BLTU] = 1'b1;
                    F3_111:  ops[OP_BGEU] = 1'b1;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                case (f3)
                    F3_000:  ops[OP_LB]  = 1'b1;
                    F3_001:  ops[OP_LH]  = 1'b1;
                    F3_010:  ops[OP_LW]  = 1'b1;
                    F3_100:  ops[OP_LBU] = 1'b1;
                    F3_101:  ops[OP_LHU] = 1'b1;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                case (f3)
                    F3_000:  ops[OP_SB] = 1'b1;
                    F3_001:  ops[OP_SH] = 1'b1;
                    F3_010:  ops[OP_SW] = 1'b1;
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                case (f3)
                    F3_000: ops[OP_ADDI]  = 1'b1;
                    F3_010: ops[OP_SLTI]  = 1'b1;
                    F3_011: ops[OP_SLTIU] = 1'b1;
                    F3_100: ops[OP_XORI]  = 1'b1;
                    F3_110: ops[OP_ORI]   = 1'b1;
                    F3_111: ops[OP_ANDI]  = 1'b1;
                    F3_001: ops[OP_SLLI]  = (f7 == F7_BASE);
                    F3_101: begin
                        ops[OP_SRLI] = (f7 == F7_BASE);
                        ops[OP_SRAI] = (f7 == F7_ALT);
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_000: ops[OP_ADD]  = 1'b1;
                        F3_001: ops[OP_SLL]  = 1'b1;
                        F3_010: ops[OP_SLT]  = 1'b1;
                        F3_011: ops[OP_SLTU] = 1'b1;
                        F3_100: ops[OP_XOR]  = 1'b1;
                        F3_101: ops[OP_SRL]  = 1'b1;
                        F3_110: ops[OP_OR]   = 1'b1;
                        F3_111: ops[OP_AND]  = 1'b1;
                        default: ;
                    endcase
                end else if (f7 == F7_ALT) begin
                    ops[OP_SUB] = (f3 == F3_000);
                    ops[OP_SRA] = (f3 == F3_101);
                end
            end
            OPC_MISC_MEM: begin
                ops[OP_FENCE]  = (f3 == F3_000);
                ops[OP_FENCEI] = (f3 == F3_001);
            end
            OPC_SYSTEM: begin
                // ecall/ebreak match the whole word; f3=000 anything else is illegal.
                if (inst == INST_ECALL) begin
                    ops[OP_ECALL] = 1'b1;
                end else if (inst == INST_EBREAK) begin
                    ops[OP_EBREAK] = 1'b1;
                end else begin
                    case (f3)
                        F3_001:  ops[OP_CSRRW]  = 1'b1;
                        F3_010:  ops[OP_CSRRS]  = 1'b1;
                        F3_011:  ops[OP_CSRRC]  = 1'b1;
                        F3_101:  ops[OP_CSRRWI] = 1'b1;
                        F3_110:  ops[OP_CSRRSI] = 1'b1;
                        F3_111:  ops[OP_CSRRCI] = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign cls_s.upper  = |ops[OP_AUIPC:OP_LUI];
    assign cls_s.jump   = |ops[OP_JALR:OP_JAL];
    assign cls_s.branch = |ops[OP_BGEU:OP_BEQ];
    assign cls_s.load   = |ops[OP_LHU:OP_LB];
    assign cls_s.store  = |ops[OP_SW:OP_SB];
    assign cls_s.imm    = |ops[OP_SRAI:OP_ADDI];
    assign cls_s.reg_op = |ops[OP_AND:OP_ADD];
    assign cls          = cls_s;

endmodule

// File: rtl/dec_swc_unit.sv
// RV32I decode stage: registers the decode of inst_in when the phase counter reaches
// DEC_CYCLE and fetch is not stalled; every output holds otherwise.
module dec_swc_unit
    import rv32i_pkg::*;
#(
    parameter logic [3:0] DEC_CYCLE = 4'd1
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic [3:0]  cycle_cnt,
    input  logic        ifu_dec_stall,
    input  logic [31:0] inst_in,
    output logic [31:0] inst_out,
    output logic        dec_lui,
    output logic        dec_auipc,
    output logic        dec_jal,
    output logic        dec_jalr,
    output logic        dec_beq,
    output logic        dec_bne,
    output logic        dec_blt,
    output logic        dec_bge,
    output logic        dec_bltu,
    output logic        dec_bgeu,
    output logic        dec_lb,
    output logic        dec_lh,
    output logic        dec_lw,
    output logic        dec_lbu,
    output logic        dec_lhu,
    output logic        dec_sb,
    output logic        dec_sh,
    output logic        dec_sw,
    output logic        dec_addi,
    output logic        dec_slti,
    output logic        dec_sltiu,
    output logic        dec_xori,
    output logic        dec_ori,
    output logic        dec_andi,
    output logic        dec_slli,
    output logic        dec_srli,
    output logic        dec_srai,
    output logic        dec_add,
    output logic        dec_sub,
    output logic        dec_sll,
    output logic        dec_slt,
    output logic        dec_sltu,
    output logic        dec_xor,
    output logic        dec_srl,
    output logic        dec_sra,
    output logic        dec_or,
    output logic        dec_and,
    output logic        dec_fence,
    output logic        dec_fence_i,
    output logic        dec_ecall,
    output logic        dec_ebreak,
    output logic        dec_csrrw,
    output logic        dec_csrrs,
    output logic        dec_csrrc,
    output logic        dec_csrrwi,
    output logic        dec_csrrsi,
    output logic        dec_csrrci,
    output logic        dec_upper_en,
    output logic        dec_imm_en,
    output logic        dec_reg_en,
    output logic        dec_jump_en,
    output logic        dec_branch_en,
    output logic        dec_load_en,
    output logic        dec_store_en,
    output logic [4:0]  dec_rs2,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rd,
    output logic [11:0] dec_imm_type_i,
    output logic [11:0] dec_imm_type_s,
    output logic [12:0] dec_imm_type_b,
    output logic [20:0] dec_imm_type_j,
    output logic [19:0] dec_imm_type_u
);

    logic [NUM_OPS-1:0] ops_d, ops_q;
    logic [NUM_CLS-1:0] cls_d;
    dec_cls_t           cls_q;
    logic [4:0]         rs1_d, rs2_d, rd_d;
    logic [11:0]        imm_i_d, imm_s_d;
    logic [12:0]        imm_b_d;
    logic [20:0]        imm_j_d;
    logic [19:0]        imm_u_d;
    logic               cap;

    dec_swc_comb u_comb (
        .inst  (inst_in),
        .ops   (ops_d),
        .cls   (cls_d),
        .rs1   (rs1_d),
        .rs2   (rs2_d),
        .rd    (rd_d),
        .imm_i (imm_i_d),
        .imm_s (imm_s_d),
        .imm_b (imm_b_d),
        .imm_j (imm_j_d),
        .imm_u (imm_u_d)
    );

    assign cap = (cycle_cnt == DEC_CYCLE) && !ifu_dec_stall;

    always_ff @(posedge hclk) begin
        if (!hrstn) begin
            inst_out       <= '0;
            ops_q          <= '0;
            cls_q          <= '0;
            dec_rs1        <= '0;
            dec_rs2        <= '0;
            dec_rd         <= '0;
            dec_imm_type_i <= '0;
            dec_imm_type_s <= '0;
            dec_imm_type_b <= '0;
            dec_imm_type_j <= '0;
            dec_imm_type_u <= '0;
        end else if (cap) begin
            inst_out       <= inst_in;
            ops_q          <= ops_d;
            cls_q          <= cls_d;
            dec_rs1        <= rs1_d;
            dec_rs2        <= rs2_d;
            dec_rd         <= rd_d;
            dec_imm_type_i <= imm_i_d;
            dec_imm_type_s <= imm_s_d;
            dec_imm_type_b <= imm_b_d;
            dec_imm_type_j <= imm_j_d;
            dec_imm_type_u <= imm_u_d;
        end
    end

    assign dec_upper_en  = cls_q.upper;
    assign dec_imm_en    = cls_q.imm;
    assign dec_reg_en    = cls_q.reg_op;
    assign dec_jump_en   = cls_q.jump;
    assign dec_branch_en = cls_q.branch;
    assign dec_load_en   = cls_q.load;
    assign dec_store_en  = cls_q.store;

    assign dec_lui     = ops_q[OP_LUI];
    assign dec_auipc   = ops_q[OP_AUIPC];
    assign dec_jal     = ops_q[OP_JAL];
    assign dec_jalr    = ops_q[OP_JALR];
    assign dec_beq     = ops_q[OP_BEQ];
    assign dec_bne     = ops_q[OP_BNE];
    assign dec_blt     = ops_q[OP_BLT];
    assign dec_bge     = ops_q[OP_BGE];
    assign dec_bltu    = ops_q[OP_BLTU];
    assign dec_bgeu    = ops_q[OP_BGEU];
    assign dec_lb      = ops_q[OP_LB];
    assign dec_lh      = ops_q[OP_LH];
    assign dec_lw      = ops_q[OP_LW];
    assign dec_lbu     = ops_q[OP_LBU];
    assign dec_lhu     = ops_q[OP_LHU];
    assign dec_sb      = ops_q[OP_SB];
    assign dec_sh      = ops_q[OP_SH];
    assign dec_sw      = ops_q[OP_SW];
    assign dec_addi    = ops_q[OP_ADDI];
    assign dec_slti    = ops_q[OP_SLTI];
    assign dec_sltiu   = ops_q[OP_SLTIU];
    assign dec_xori    = ops_q[OP_XORI];
    assign dec_ori     = ops_q[OP_ORI];
    assign dec_andi    = ops_q[OP_ANDI];
    assign dec_slli    = ops_q[OP_SLLI];
    assign dec_srli    = ops_q[OP_SRLI];
    assign dec_srai    = ops_q[OP_SRAI];
    assign dec_add     = ops_q[OP_ADD];
    assign dec_sub     = ops_q[OP_SUB];
    assign dec_sll     = ops_q[OP_SLL];
    assign dec_slt     = ops_q[OP_SLT];
    assign dec_sltu    = ops_q[OP_SLTU];
    assign dec_xor     = ops_q[OP_XOR];
    assign dec_srl     = ops_q[OP_SRL];
    assign dec_sra     = ops_q[OP_SRA];
    assign dec_or      = ops_q[OP_OR];
    assign dec_and     = ops_q[OP_AND];
    assign dec_fence   = ops_q[OP_FENCE];
    assign dec_fence_i = ops_q[OP_FENCEI];
    assign dec_ecall   = ops_q[OP_ECALL];
    assign dec_ebreak  = ops_q[OP_EBREAK];
    assign dec_csrrw   = ops_q[OP_CSRRW];
    assign dec_csrrs   = ops_q[OP_CSRRS];
    assign dec_csrrc   = ops_q[OP_CSRRC];
    assign dec_csrrwi  = ops_q[OP_CSRRWI];
    assign dec_csrrsi  = ops_q[OP_CSRRSI];
    assign dec_csrrci  = ops_q[OP_CSRRCI];

endmodule

// File: tb/tb_dec_swc_unit.sv
// Directed bench for dec_swc_unit: hand-decoded RV32I words checked after each capture edge,
// plus reset, stall/phase hold and illegal-encoding cases.
module tb_dec_swc_unit;

    logic        hclk = 1'b0;
    logic        hrstn;
    logic [3:0]  cycle_cnt;
    logic        ifu_dec_stall;
    logic [31:0] inst_in;
    logic [31:0] inst_out;
    logic dec_lui, dec_auipc, dec_jal, dec_jalr, dec_beq, dec_bne, dec_blt, dec_bge, dec_bltu, dec_bgeu;
    logic dec_lb, dec_lh, dec_lw, dec_lbu, dec_lhu, dec_sb, dec_sh, dec_sw;
    logic dec_addi, dec_slti, dec_sltiu, dec_xori, dec_ori, dec_andi, dec_slli, dec_srli, dec_srai;
    logic dec_add, dec_sub, dec_sll, dec_slt, dec_sltu, dec_xor, dec_srl, dec_sra, dec_or, dec_and;
    logic dec_fence, dec_fence_i, dec_ecall, dec_ebreak;
    logic dec_csrrw, dec_csrrs, dec_csrrc, dec_csrrwi, dec_csrrsi, dec_csrrci;
    logic dec_upper_en, dec_imm_en, dec_reg_en, dec_jump_en, dec_branch_en, dec_load_en, dec_store_en;
    logic [4:0]  dec_rs2, dec_rs1, dec_rd;
    logic [11:0] dec_imm_type_i, dec_imm_type_s;
    logic [12:0] dec_imm_type_b;
    logic [20:0] dec_imm_type_j;
    logic [19:0] dec_imm_type_u;

    logic [46:0] flags;
    logic [6:0]  cls;
    int errors = 0;
    int checks = 0;

    // Bit positions in the order the ops are listed: lui=0 ... csrrci=46.
    localparam int T_LUI = 0, T_JAL = 2, T_BEQ = 4, T_LBU = 13, T_SW = 17, T_ADDI = 18, T_SRAI = 26;
    localparam int T_ADD = 27, T_SUB = 28, T_FENCEI = 38, T_ECALL = 39, T_EBREAK = 40, T_CSRRW = 41;
    // Class positions: upper=0 imm=1 reg=2 jump=3 branch=4 load=5 store=6.
    localparam int C_UP = 0, C_IMM = 1, C_REG = 2, C_JMP = 3, C_BR = 4, C_LD = 5, C_ST = 6;

    assign flags = {dec_csrrci, dec_csrrsi, dec_csrrwi, dec_csrrc, dec_csrrs, dec_csrrw,
                    dec_ebreak, dec_ecall, dec_fence_i, dec_fence,
                    dec_and, dec_or, dec_sra, dec_srl, dec_xor, dec_sltu, dec_slt, dec_sll, dec_sub, dec_add,
                    dec_srai, dec_srli, dec_slli, dec_andi, dec_ori, dec_xori, dec_sltiu, dec_slti, dec_addi,
                    dec_sw, dec_sh, dec_sb, dec_lhu, dec_lbu, dec_lw, dec_lh, dec_lb,
                    dec_bgeu, dec_bltu, dec_bge, dec_blt, dec_bne, dec_beq, dec_jalr, dec_jal, dec_auipc, dec_lui};
    assign cls = {dec_store_en, dec_load_en, dec_branch_en, dec_jump_en, dec_reg_en, dec_imm_en, dec_upper_en};

    dec_swc_unit #(.DEC_CYCLE(4'd1)) dut (
        .hclk(hclk), .hrstn(hrstn), .cycle_cnt(cycle_cnt), .ifu_dec_stall(ifu_dec_stall),
        .inst_in(inst_in), .inst_out(inst_out),
        .dec_lui(dec_lui), .dec_auipc(dec_auipc), .dec_jal(dec_jal), .dec_jalr(dec_jalr),
        .dec_beq(dec_beq), .dec_bne(dec_bne), .dec_blt(dec_blt), .dec_bge(dec_bge),
        .dec_bltu(dec_bltu), .dec_bgeu(dec_bgeu),
        .dec_lb(dec_lb), .dec_lh(dec_lh), .dec_lw(dec_lw), .dec_lbu(dec_lbu), .dec_lhu(dec_lhu),
        .dec_sb(dec_sb), .dec_sh(dec_sh), .dec_sw(dec_sw),
        .dec_addi(dec_addi), .dec_slti(dec_slti), .dec_sltiu(dec_sltiu), .dec_xori(dec_xori),
        .dec_ori(dec_ori), .dec_andi(dec_andi), .dec_slli(dec_slli), .dec_srli(dec_srli), .dec_srai(dec_srai),
        .dec_add(dec_add), .dec_sub(dec_sub), .dec_sll(dec_sll), .dec_slt(dec_slt), .dec_sltu(dec_sltu),
        .dec_xor(dec_xor), .dec_srl(dec_srl), .dec_sra(dec_sra), .dec_or(dec_or), .dec_and(dec_and),
        .dec_fence(dec_fence), .dec_fence_i(dec_fence_i), .dec_ecall(dec_ecall), .dec_ebreak(dec_ebreak),
        .dec_csrrw(dec_csrrw), .dec_csrrs(dec_csrrs), .dec_csrrc(dec_csrrc),
        .dec_csrrwi(dec_csrrwi), .dec_csrrsi(dec_csrrsi), .dec_csrrci(dec_csrrci),
        .dec_upper_en(dec_upper_en), .dec_imm_en(dec_imm_en), .dec_reg_en(dec_reg_en),
        .dec_jump_en(dec_jump_en), .dec_branch_en(dec_branch_en), .dec_load_en(dec_load_en),
        .dec_store_en(dec_store_en),
        .dec_rs2(dec_rs2), .dec_rs1(dec_rs1), .dec_rd(dec_rd),
        .dec_imm_type_i(dec_imm_type_i), .dec_imm_type_s(dec_imm_type_s), .dec_imm_type_b(dec_imm_type_b),
        .dec_imm_type_j(dec_imm_type_j), .dec_imm_type_u(dec_imm_type_u)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive mid-cycle, let one rising edge happen, then sample 1 time unit later.
    task automatic step(input logic [31:0] i, input logic [3:0] c, input logic s, input logic r);
        @(negedge hclk);
        inst_in = i; cycle_cnt = c; ifu_dec_stall = s; hrstn = r;
        @(posedge hclk);
        #1;
    endtask

    task automatic expect_dec(input string tag, input logic [31:0] e_inst, input int op, input int c);
        logic [46:0] ef;
        logic [6:0]  ec;
        ef = '0;
        ec = '0;
        if (op >= 0) ef[op] = 1'b1;
        if (c >= 0) ec[c] = 1'b1;
        chk({tag, ".inst_out"}, 64'(inst_out), 64'(e_inst));
        chk({tag, ".flags"}, 64'(flags), 64'(ef));
        chk({tag, ".cls"}, 64'(cls), 64'(ec));
    endtask

    task automatic expect_zero_fields(input string tag);
        chk({tag, ".rs"}, 64'({dec_rs2, dec_rs1, dec_rd}), 64'd0);
        chk({tag, ".imm_isb"}, 64'({dec_imm_type_i, dec_imm_type_s, dec_imm_type_b}), 64'd0);
        chk({tag, ".imm_ju"}, 64'({dec_imm_type_j, dec_imm_type_u}), 64'd0);
    endtask

    initial begin
        // Reset wins over a legal capture request.
        step(32'h0050_0093, 4'd1, 1'b0, 1'b0);
        expect_dec("reset", 32'h0, -1, -1);
        expect_zero_fields("reset");

        step(32'h0050_0093, 4'd1, 1'b0, 1'b1);
        expect_dec("addi", 32'h0050_0093, T_ADDI, C_IMM);
        chk("addi.rd", 64'(dec_rd), 64'd1);
        chk("addi.rs1", 64'(dec_rs1), 64'd0);
        chk("addi.imm_i", 64'(dec_imm_type_i), 64'h005);

        step(32'h4020_81B3, 4'd1, 1'b0, 1'b1);
        expect_dec("sub", 32'h4020_81B3, T_SUB, C_REG);
        chk("sub.rd", 64'(dec_rd), 64'd3);
        chk("sub.rs1", 64'(dec_rs1), 64'd1);
        chk("sub.rs2", 64'(dec_rs2), 64'd2);

        step(32'h0020_81B3, 4'd1, 1'b0, 1'b1);
        expect_dec("add", 32'h0020_81B3, T_ADD, C_REG);

        step(32'h0020_8463, 4'd1, 1'b0, 1'b1);
        expect_dec("beq", 32'h0020_8463, T_BEQ, C_BR);
        chk("beq.imm_b", 64'(dec_imm_type_b), 64'h008);

        step(32'hFFDF_F06F, 4'd1, 1'b0, 1'b1);
        expect_dec("jal", 32'hFFDF_F06F, T_JAL, C_JMP);
        chk("jal.rd", 64'(dec_rd), 64'd0);
        chk("jal.imm_j", 64'(dec_imm_type_j), 64'h1F_FFFC);

        step(32'h0020_A623, 4'd1, 1'b0, 1'b1);
        expect_dec("sw", 32'h0020_A623, T_SW, C_ST);
        chk("sw.imm_s", 64'(dec_imm_type_s), 64'h00C);

        step(32'h1234_52B7, 4'd1, 1'b0, 1'b1);
        expect_dec("lui", 32'h1234_52B7, T_LUI, C_UP);
        chk("lui.imm_u", 64'(dec_imm_type_u), 64'h12345);
        chk("lui.rd", 64'(dec_rd), 64'd5);

        step(32'h0000_4083, 4'd1, 1'b0, 1'b1);
        expect_dec("lbu", 32'h0000_4083, T_LBU, C_LD);

        step(32'h0000_0073, 4'd1, 1'b0, 1'b1);
        expect_dec("ecall", 32'h0000_0073, T_ECALL, -1);
        step(32'h0010_0073, 4'd1, 1'b0, 1'b1);
        expect_dec("ebreak", 32'h0010_0073, T_EBREAK, -1);
        step(32'h0000_1073, 4'd1, 1'b0, 1'b1);
        expect_dec("csrrw", 32'h0000_1073, T_CSRRW, -1);
        step(32'h0000_100F, 4'd1, 1'b0, 1'b1);
        expect_dec("fence_i", 32'h0000_100F, T_FENCEI, -1);
        step(32'h4000_5013, 4'd1, 1'b0, 1'b1);
        expect_dec("srai", 32'h4000_5013, T_SRAI, C_IMM);

        // Near-miss encodings that must decode to nothing.
        step(32'h4000_1013, 4'd1, 1'b0, 1'b1);
        expect_dec("slli_f7alt", 32'h4000_1013, -1, -1);
        step(32'h0000_2063, 4'd1, 1'b0, 1'b1);
        expect_dec("br_f3_010", 32'h0000_2063, -1, -1);
        step(32'h0000_3003, 4'd1, 1'b0, 1'b1);
        expect_dec("ld_f3_011", 32'h0000_3003, -1, -1);
        step(32'h0000_0173, 4'd1, 1'b0, 1'b1);
        expect_dec("sys_f3_000", 32'h0000_0173, -1, -1);
        step(32'h0050_0091, 4'd1, 1'b0, 1'b1);
        expect_dec("low_bits", 32'h0050_0091, -1, -1);
        step(32'hFFFF_FFFF, 4'd1, 1'b0, 1'b1);
        expect_dec("all_ones", 32'hFFFF_FFFF, -1, -1);
        chk("all_ones.rd", 64'(dec_rd), 64'd31);
        chk("all_ones.imm_u", 64'(dec_imm_type_u), 64'hF_FFFF);

        // Hold under stall and outside the decode phase.
        step(32'h0050_0093, 4'd1, 1'b0, 1'b1);
        expect_dec("hold_base", 32'h0050_0093, T_ADDI, C_IMM);
        step(32'h0020_81B3, 4'd1, 1'b1, 1'b1);
        expect_dec("hold_stall", 32'h0050_0093, T_ADDI, C_IMM);
        chk("hold_stall.imm_i", 64'(dec_imm_type_i), 64'h005);
        step(32'h0020_81B3, 4'd2, 1'b0, 1'b1);
        expect_dec("hold_cnt2", 32'h0050_0093, T_ADDI, C_IMM);
        chk("hold_cnt2.rd", 64'(dec_rd), 64'd1);
        step(32'h0020_81B3, 4'd1, 1'b1, 1'b0);
        expect_dec("rst_in_stall", 32'h0, -1, -1);
        expect_zero_fields("rst_in_stall");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
